// File: rtl/motor_cmd_dispatch.sv
// Per-channel 2-deep motion command queue with a round-robin loader onto one shared controller load bus.
// cmd_valid to mc_load is 2 cycles minimum; a full queue rejects commands, and a channel is held off while busy or its controller is active.
module motor_cmd_dispatch #(
    parameter int NUM_CH = 10,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 11,
    parameter int ACK_TO = 15
) (
    input  logic              CLOCK_25,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_ch,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    output logic              cmd_accept,
    output logic              cmd_reject,
    input  logic              abort_valid,
    input  logic [3:0]        abort_ch,
    output logic [NUM_CH-1:0] mc_load,
    output logic [DIV_W-1:0]  mc_div,
    output logic [STEP_W-1:0] mc_steps,
    output logic              mc_dir,
    input  logic [NUM_CH-1:0] mc_active,
    output logic [NUM_CH-1:0] q_pending,
    output logic [NUM_CH-1:0] q_full,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] fault
);
    localparam int CH_W = 4;
    localparam int TO_W = $clog2(ACK_TO + 1);

    typedef struct packed {
        logic [DIV_W-1:0]  div;
        logic [STEP_W-1:0] steps;
        logic              dir;
    } motorCmd_t;

    motorCmd_t         headQ    [NUM_CH];
    motorCmd_t         tailQ    [NUM_CH];
    logic [1:0]        qCount   [NUM_CH];
    logic [TO_W-1:0]   ackTimer [NUM_CH];
    logic [NUM_CH-1:0] busyR;
    logic [NUM_CH-1:0] actR;
    logic [NUM_CH-1:0] faultR;
    logic [CH_W-1:0]   rrPtr;

    logic [NUM_CH-1:0] abortVec;
    logic [NUM_CH-1:0] pushVec;
    logic [NUM_CH-1:0] popVec;
    logic [NUM_CH-1:0] elig;
    logic              cmdOk;
    logic              grantVld;
    logic [CH_W-1:0]   grantCh;
    motorCmd_t         grantCmd;
    motorCmd_t         newCmd;

    always_comb begin
        abortVec = '0;
        pushVec  = '0;
        popVec   = '0;
        elig     = '0;
        cmdOk    = 1'b0;
        grantVld = 1'b0;
        grantCh  = '0;
        grantCmd = '0;
        newCmd   = {cmd_div, cmd_steps, cmd_dir};

        for (int c = 0; c < NUM_CH; c++) begin
            abortVec[c] = abort_valid && (abort_ch == CH_W'(c));
            elig[c]     = (qCount[c] != 2'd0) && !busyR[c] && !mc_active[c];
            // Out-of-range channels never match here, so they fall through to reject.
            if (cmd_valid && (cmd_ch == CH_W'(c)) && (cmd_steps != '0)
                && (qCount[c] != 2'd2) && !abortVec[c]) begin
                cmdOk      = 1'b1;
                pushVec[c] = 1'b1;
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (!grantVld && elig[(int'(rrPtr) + i) % NUM_CH]) begin
                grantVld = 1'b1;
                grantCh  = CH_W'((int'(rrPtr) + i) % NUM_CH);
            end
        end
        // An abort on the winning channel cancels the whole grant this cycle.
        if (grantVld && abort_valid && (abort_ch == grantCh)) begin
            grantVld = 1'b0;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (grantVld && (grantCh == CH_W'(c))) begin
                popVec[c] = 1'b1;
                grantCmd  = headQ[c];
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                headQ[c]    <= '0;
                tailQ[c]    <= '0;
                qCount[c]   <= 2'd0;
                ackTimer[c] <= '0;
            end
            busyR      <= '0;
            actR       <= '0;
            faultR     <= '0;
            rrPtr      <= '0;
            cmd_accept <= 1'b0;
            cmd_reject <= 1'b0;
            mc_load    <= '0;
            mc_div     <= '0;
            mc_steps   <= '0;
            mc_dir     <= 1'b0;
        end else begin
            cmd_accept <= cmdOk;
            cmd_reject <= cmd_valid && !cmdOk;
            mc_load    <= popVec;
            if (grantVld) begin
                mc_div   <= grantCmd.div;
                mc_steps <= grantCmd.steps;
                mc_dir   <= grantCmd.dir;
                rrPtr    <= (int'(grantCh) == NUM_CH - 1) ? '0 : grantCh + 1'b1;
            end

            for (int c = 0; c < NUM_CH; c++) begin
                if (popVec[c]) begin
                    busyR[c]    <= 1'b1;
                    actR[c]     <= 1'b0;
                    ackTimer[c] <= TO_W'(ACK_TO);
                end else if (busyR[c]) begin
                    actR[c] <= mc_active[c];
                    if (actR[c] && !mc_active[c]) begin
                        busyR[c] <= 1'b0;
                    end else if (!actR[c] && !mc_active[c] && (ackTimer[c] == '0)) begin
                        busyR[c]  <= 1'b0;
                        faultR[c] <= 1'b1;
                    end else if (!actR[c] && (ackTimer[c] != '0)) begin
                        ackTimer[c] <= ackTimer[c] - 1'b1;
                    end
                end

                // Pop with push only happens at count 1, so the new command becomes head.
                if (abortVec[c]) begin
                    qCount[c] <= 2'd0;
                    faultR[c] <= 1'b0;
                end else if (popVec[c] && pushVec[c]) begin
                    headQ[c] <= newCmd;
                end else if (popVec[c]) begin
                    headQ[c]  <= tailQ[c];
                    qCount[c] <= qCount[c] - 2'd1;
                end else if (pushVec[c]) begin
                    if (qCount[c] == 2'd0) headQ[c] <= newCmd;
                    else                   tailQ[c] <= newCmd;
                    qCount[c] <= qCount[c] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        q_pending = '0;
        q_full    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            q_pending[c] = (qCount[c] != 2'd0);
            q_full[c]    = (qCount[c] == 2'd2);
        end
        busy  = busyR;
        fault = faultR;
    end

endmodule

// File: tb/tb_motor_cmd_dispatch.sv
// Bench for motor_cmd_dispatch: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_motor_cmd_dispatch;
    localparam int NUM_CH = 10;
    localparam int ACK_TO = 15;

    typedef struct packed {
        logic [15:0] div;
        logic [10:0] steps;
        logic        dir;
    } cmd_t;

    logic              CLOCK_25 = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmdValid = 1'b0;
    logic [3:0]        cmdCh = '0;
    logic [15:0]       cmdDiv = '0;
    logic [10:0]       cmdSteps = '0;
    logic              cmdDir = 1'b0;
    logic              abortValid = 1'b0;
    logic [3:0]        abortCh = '0;
    logic [NUM_CH-1:0] mcActive = '0;
    logic              cmd_accept, cmd_reject, mc_dir;
    logic [NUM_CH-1:0] mc_load, q_pending, q_full, busy, fault;
    logic [15:0]       mc_div;
    logic [10:0]       mc_steps;

    int errors = 0;
    int checks = 0;

    motor_cmd_dispatch #(.NUM_CH(NUM_CH), .DIV_W(16), .STEP_W(11), .ACK_TO(ACK_TO)) dut (
        .CLOCK_25(CLOCK_25), .reset_n(reset_n),
        .cmd_valid(cmdValid), .cmd_ch(cmdCh), .cmd_div(cmdDiv), .cmd_steps(cmdSteps), .cmd_dir(cmdDir),
        .cmd_accept(cmd_accept), .cmd_reject(cmd_reject),
        .abort_valid(abortValid), .abort_ch(abortCh),
        .mc_load(mc_load), .mc_div(mc_div), .mc_steps(mc_steps), .mc_dir(mc_dir),
        .mc_active(mcActive), .q_pending(q_pending), .q_full(q_full), .busy(busy), .fault(fault)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    // Reference model: a queue per channel, a run flag, and an age count since load.
    cmd_t              mq [NUM_CH][$];
    bit                mBusy [NUM_CH];
    bit                mSeen [NUM_CH];
    int                mAge [NUM_CH];
    bit                mFault [NUM_CH];
    int                mRr;
    logic [NUM_CH-1:0] mLoad;
    cmd_t              mOut;
    bit                mAcc, mRej, mTake;
    int                mGrant;

    always @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mq[c].delete();
                mBusy[c] = 0; mSeen[c] = 0; mAge[c] = 0; mFault[c] = 0;
            end
            mRr = 0; mLoad = '0; mOut = '0; mAcc = 0; mRej = 0;
        end else begin
            mTake = 0;
            if (cmdValid && int'(cmdCh) < NUM_CH && cmdSteps != 0) begin
                if (mq[cmdCh].size() < 2 && !(abortValid && abortCh == cmdCh)) mTake = 1;
            end
            mGrant = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (mGrant < 0 && mq[(mRr + i) % NUM_CH].size() > 0 && !mBusy[(mRr + i) % NUM_CH]
                    && !mcActive[(mRr + i) % NUM_CH]) mGrant = (mRr + i) % NUM_CH;
            end
            if (mGrant >= 0 && abortValid && int'(abortCh) == mGrant) mGrant = -1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mBusy[c]) begin
                    if (mSeen[c]) begin
                        if (!mcActive[c]) mBusy[c] = 0;
                    end else if (mcActive[c]) begin
                        mSeen[c] = 1;
                    end else if (mAge[c] == ACK_TO) begin
                        mBusy[c] = 0; mFault[c] = 1;
                    end else begin
                        mAge[c]++;
                    end
                end
            end
            mLoad = '0;
            if (mGrant >= 0) begin
                mLoad[mGrant] = 1'b1;
                mOut = mq[mGrant].pop_front();
                mBusy[mGrant] = 1; mSeen[mGrant] = 0; mAge[mGrant] = 0;
                mRr = (mGrant + 1) % NUM_CH;
            end
            mAcc = mTake;
            mRej = cmdValid && !mTake;
            if (mTake) mq[cmdCh].push_back({cmdDiv, cmdSteps, cmdDir});
            if (abortValid && int'(abortCh) < NUM_CH) begin
                mq[abortCh].delete();
                mFault[abortCh] = 0;
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK_25);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; cmdValid = 0; abortValid = 0; mcActive = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic send(input int ch, input int div, input int steps, input bit dir);
        cmdValid = 1'b1; cmdCh = 4'(ch); cmdDiv = 16'(div); cmdSteps = 11'(steps); cmdDir = dir;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_accept, cmd_reject, mc_load, mc_div, mc_steps, mc_dir, q_pending, q_full, busy, fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: load=%h pend=%h busy=%h fault=%h, required all zero",
                     mc_load, q_pending, busy, fault);
        end
        apply_reset();
    endtask

    task automatic test_single_load();
        send(3, 'h0100, 5, 1);
        checks++;
        if (cmd_accept !== 1'b1 || q_pending !== 10'h008) begin
            errors++; $display("FAIL single_accept: accept=%b pend=%h, required 1 / 008", cmd_accept, q_pending);
        end
        tick();
        checks++;
        if (mc_load !== 10'h008 || mc_div !== 16'h0100 || mc_steps !== 11'd5 || mc_dir !== 1'b1) begin
            errors++; $display("FAIL single_load: load=%h div=%h steps=%0d dir=%b, required 008/0100/5/1",
                               mc_load, mc_div, mc_steps, mc_dir);
        end
        mcActive[3] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy[3] !== 1'b1 || mc_load !== '0) begin
            errors++; $display("FAIL single_busy_run: busy3=%b load=%h, required 1 / 000", busy[3], mc_load);
        end
        mcActive[3] = 1'b0;
        tick();
        checks++;
        if (busy[3] !== 1'b0) begin
            errors++; $display("FAIL single_busy_clear: busy3=%b, required 0", busy[3]);
        end
    endtask

    task automatic test_queue_full();
        apply_reset();
        send(0, 'h0011, 1, 0);
        tick();
        mcActive[0] = 1'b1;
        send(0, 'h0022, 2, 1);
        checks++;
        if (cmd_accept !== 1'b1) begin errors++; $display("FAIL full_second: accept=%b, required 1", cmd_accept); end
        send(0, 'h0033, 3, 0);
        checks++;
        if (cmd_accept !== 1'b1) begin errors++; $display("FAIL full_third: accept=%b, required 1", cmd_accept); end
        send(0, 'h0044, 4, 1);
        checks++;
        if (cmd_reject !== 1'b1 || cmd_accept !== 1'b0 || q_full[0] !== 1'b1) begin
            errors++; $display("FAIL full_reject: reject=%b accept=%b full0=%b, required 1/0/1",
                               cmd_reject, cmd_accept, q_full[0]);
        end
        mcActive[0] = 1'b0;
        tick(); tick();
        checks++;
        if (mc_load !== 10'h001 || mc_steps !== 11'd2 || mc_div !== 16'h0022) begin
            errors++; $display("FAIL full_order_b: load=%h steps=%0d div=%h, required 001/2/0022", mc_load, mc_steps, mc_div);
        end
        mcActive[0] = 1'b1; tick();
        mcActive[0] = 1'b0; tick(); tick();
        checks++;
        if (mc_load !== 10'h001 || mc_steps !== 11'd3 || q_pending[0] !== 1'b0) begin
            errors++; $display("FAIL full_order_c: load=%h steps=%0d pend0=%b, required 001/3/0", mc_load, mc_steps, q_pending[0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mcActive = 10'h224;
        send(2, 2, 2, 0); send(5, 5, 5, 0); send(9, 9, 9, 1);
        mcActive = '0;
        tick();
        checks++;
        if (mc_load !== 10'h004) begin errors++; $display("FAIL rr_first: load=%h, required 004", mc_load); end
        tick();
        checks++;
        if (mc_load !== 10'h020) begin errors++; $display("FAIL rr_second: load=%h, required 020", mc_load); end
        tick();
        checks++;
        if (mc_load !== 10'h200 || mc_steps !== 11'd9) begin
            errors++; $display("FAIL rr_third: load=%h steps=%0d, required 200/9", mc_load, mc_steps);
        end
        mcActive = 10'h101;
        send(8, 8, 8, 0); send(0, 1, 1, 0);
        mcActive = '0;
        tick();
        checks++;
        if (mc_load !== 10'h001) begin errors++; $display("FAIL rr_wrap: load=%h, required 001", mc_load); end
        tick();
        checks++;
        if (mc_load !== 10'h100) begin errors++; $display("FAIL rr_wrap_next: load=%h, required 100", mc_load); end
    endtask

    task automatic test_reject();
        apply_reset();
        send(12, 7, 5, 0);
        checks++;
        if (cmd_reject !== 1'b1 || cmd_accept !== 1'b0 || q_pending !== '0) begin
            errors++; $display("FAIL reject_badch: reject=%b accept=%b pend=%h, required 1/0/000", cmd_reject, cmd_accept, q_pending);
        end
        send(3, 7, 0, 0);
        checks++;
        if (cmd_reject !== 1'b1 || q_pending !== '0) begin
            errors++; $display("FAIL reject_zero: reject=%b pend=%h, required 1/000", cmd_reject, q_pending);
        end
        tick();
        checks++;
        if (mc_load !== '0 || busy !== '0) begin
            errors++; $display("FAIL reject_noload: load=%h busy=%h, required 000/000", mc_load, busy);
        end
    endtask

    task automatic test_fault_abort();
        apply_reset();
        send(1, 3, 3, 0);
        tick();
        checks++;
        if (mc_load !== 10'h002) begin errors++; $display("FAIL fault_load: load=%h, required 002", mc_load); end
        for (int i = 0; i < ACK_TO; i++) tick();
        checks++;
        if (fault[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++; $display("FAIL fault_early: fault1=%b busy1=%b at L+15, required 0/1", fault[1], busy[1]);
        end
        tick();
        checks++;
        if (fault[1] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++; $display("FAIL fault_set: fault1=%b busy1=%b at L+16, required 1/0", fault[1], busy[1]);
        end
        mcActive[1] = 1'b1;
        send(1, 4, 4, 1);
        abortValid = 1'b1; abortCh = 4'd1;
        tick();
        abortValid = 1'b0;
        checks++;
        if (fault[1] !== 1'b0 || q_pending[1] !== 1'b0) begin
            errors++; $display("FAIL abort_clear: fault1=%b pend1=%b, required 0/0", fault[1], q_pending[1]);
        end
        mcActive[1] = 1'b0;
    endtask

    task automatic test_abort_push();
        apply_reset();
        mcActive[4] = 1'b1;
        send(4, 6, 6, 0);
        mcActive[4] = 1'b0;
        abortValid = 1'b1; abortCh = 4'd4;
        send(4, 7, 7, 1);
        abortValid = 1'b0;
        checks++;
        if (cmd_reject !== 1'b1 || q_pending[4] !== 1'b0) begin
            errors++; $display("FAIL abort_push: reject=%b pend4=%b, required 1/0", cmd_reject, q_pending[4]);
        end
        checks++;
        if (mc_load !== '0) begin errors++; $display("FAIL abort_grant: load=%h, required 000", mc_load); end
        tick();
        checks++;
        if (mc_load !== '0 || busy[4] !== 1'b0) begin
            errors++; $display("FAIL abort_nolater: load=%h busy4=%b, required 000/0", mc_load, busy[4]);
        end
    endtask

    task automatic test_random();
        int emuDly [NUM_CH];
        int emuRun [NUM_CH];
        logic [NUM_CH-1:0] ePend, eFull, eBusy, eFault;
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) begin emuDly[c] = -1; emuRun[c] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ePend[c] = mq[c].size() != 0; eFull[c] = mq[c].size() == 2;
                eBusy[c] = mBusy[c]; eFault[c] = mFault[c];
            end
            checks++;
            if ({mc_load, cmd_accept, cmd_reject} !== {mLoad, mAcc, mRej}) begin
                errors++; $display("FAIL rand_strobes cyc %0d: load=%h acc=%b rej=%b, required %h/%b/%b",
                                   cyc, mc_load, cmd_accept, cmd_reject, mLoad, mAcc, mRej);
            end
            checks++;
            if ({mc_div, mc_steps, mc_dir} !== mOut) begin
                errors++; $display("FAIL rand_fields cyc %0d: got %h, required %h", cyc, {mc_div, mc_steps, mc_dir}, mOut);
            end
            checks++;
            if ({q_pending, q_full, busy, fault} !== {ePend, eFull, eBusy, eFault}) begin
                errors++; $display("FAIL rand_status cyc %0d: pend=%h full=%h busy=%h fault=%h, required %h/%h/%h/%h",
                                   cyc, q_pending, q_full, busy, fault, ePend, eFull, eBusy, eFault);
            end
            // Motor emulation: start after 0-3 cycles (or never), run 1-5 cycles.
            for (int c = 0; c < NUM_CH; c++) begin
                if (mLoad[c]) begin
                    emuDly[c] = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
                    emuRun[c] = $urandom_range(1, 5);
                end else if (emuDly[c] > 0 && emuDly[c] < 1000) begin
                    emuDly[c]--;
                end else if (emuDly[c] == 0) begin
                    if (emuRun[c] > 0) begin mcActive[c] = 1'b1; emuRun[c]--; end
                    else begin mcActive[c] = 1'b0; emuDly[c] = -1; end
                end
            end
            cmdValid   = $urandom_range(0, 1);
            cmdCh      = 4'($urandom_range(0, 11));
            cmdDiv     = 16'($urandom);
            cmdSteps   = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
            cmdDir     = 1'($urandom);
            abortValid = ($urandom_range(0, 39) == 0);
            abortCh    = 4'($urandom_range(0, NUM_CH - 1));
            tick();
        end
        cmdValid = 1'b0; abortValid = 1'b0;
    endtask

    task automatic test_midrun_reset();
        mcActive = '0;
        send(6, 1, 1, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mc_load, q_pending, busy, fault, cmd_accept, mc_steps} !== '0) begin
            errors++; $display("FAIL midrun_reset: load=%h pend=%h busy=%h steps=%0d, required all zero",
                               mc_load, q_pending, busy, mc_steps);
        end
        tick();
        checks++;
        if (mc_load !== '0) begin errors++; $display("FAIL midrun_noload: load=%h, required 000", mc_load); end
        reset_n = 1'b1;
    endtask

    initial begin
        tick();
        test_reset();
        test_single_load();
        test_queue_full();
        test_back_to_back();
        test_reject();
        test_fault_abort();
        test_abort_push();
        test_random();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_cmd_dispatch.md
# motor_cmd_dispatch

Per-axis command queue and dispatcher sitting between the UART command parser and the ten step-generator motor controllers. It buffers up to two parsed motion commands (divider, step count, direction) per channel. A round-robin arbiter loads each queued command into its motor controller over one shared load bus once that controller has finished its previous run. It replaces the single-slot pending flags with per-channel queue, busy and fault status for the status reporter.

## Interface
- NUM_CH, 10, number of motor channels (max 16)
- DIV_W, 16, step-rate divider width
- STEP_W, 11, step-count width
- ACK_TO, 15, cycles after mc_load within which mc_active must rise
- CLOCK_25  in  1  system clock, 25 MHz. One clock domain.
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe: command fields valid
- cmd_ch  in  4  target channel
- cmd_div  in  DIV_W  divider
- cmd_steps  in  STEP_W  step count
- cmd_dir  in  1  direction
- cmd_accept  out  1  registered pulse: command queued
- cmd_reject  out  1  registered pulse: command dropped
- abort_valid  in  1  one-cycle strobe: flush channel abort_ch
- abort_ch  in  4  channel to flush
- mc_load  out  NUM_CH  one-hot load strobe, at most one bit per cycle
- mc_div  out  DIV_W  divider for the loaded channel
- mc_steps  out  STEP_W  step count for the loaded channel
- mc_dir  out  1  direction for the loaded channel
- mc_active  in  NUM_CH  per-controller running flag
- q_pending  out  NUM_CH  queue count != 0
- q_full  out  NUM_CH  queue count == 2
- busy  out  NUM_CH  command loaded and run not yet complete
- fault  out  NUM_CH  sticky: controller never went active after a load

## Operation
- Per channel: 2-entry FIFO (head, tail), 2-bit count, busy bit, act_r (registered mc_active), ACK_TO counter, fault bit.
- Command write, with all decisions taken from state at the start of the cycle:
  - reject if cmd_ch >= NUM_CH, if cmd_steps == 0, if count == 2 (even if a pop happens in the same cycle), or if abort_valid targets the same channel in the same cycle;
  - otherwise push at count position and pulse cmd_accept.
- Eligibility for channel c: count > 0, busy == 0, mc_active[c] == 0.
- Arbiter:
  - round-robin pointer rr (reset 0); grant the first eligible channel searching rr, rr+1, ... modulo NUM_CH;
  - on grant of channel k, rr <= k+1 (wraps NUM_CH-1 -> 0);
  - no grant leaves rr unchanged.
- Grant of channel k, registered:
  - next cycle mc_load[k] = 1 and mc_div/mc_steps/mc_dir = head of k;
  - the same edge pops the FIFO (tail -> head, count - 1), sets busy[k], clears act_r[k] and loads timeout = ACK_TO.
- Run tracking while busy[k]:
  - act_r[k] <= mc_active[k];
  - busy clears on the falling edge (act_r=1, mc_active=0);
  - if mc_active has not risen and the timeout reaches 0, busy clears and fault[k] sets.
- Push and pop on the same channel in one cycle are both applied (net count unchanged).
- Abort of channel c:
  - count <= 0, fault[c] <= 0;
  - busy and an in-flight motor run are not affected;
  - abort wins over a grant to c issued in the same cycle: the grant is suppressed and rr does not advance.
- mc_div/mc_steps/mc_dir hold their last value when no load is issued.

## Timing
- Reset: all outputs 0, queues empty, rr = 0, act_r = 0.
- cmd_accept/cmd_reject are asserted exactly one cycle after cmd_valid.
- Minimum cmd_valid (cycle t) to mc_load latency is 2 cycles: entry visible at t+1, mc_load at t+2.
- Maximum throughput is one mc_load per cycle across all channels.
- A channel gets its next load no earlier than 1 cycle after the falling edge of mc_active.
- Fault timing: after mc_load at cycle L with mc_active held low, fault is set at L+ACK_TO+1.
- Reset asserted mid-run clears all state immediately, with no final load.

## Test plan
- Push ch 3 (div 0x0100, steps 5, dir 1) at t -> cmd_accept at t+1, mc_load = 0x008 at t+2 with matching fields. Busy[3] stays set until mc_active[3] falls.
- Three pushes to ch 0 while mc_active[0] = 1 and busy -> first two accepted, third rejected. q_full[0] = 1; entries load in order after each run ends.
- Heads queued on ch 2, 5 and 9 in the same cycle, rr = 0 -> loads on consecutive cycles 2, 5, 9. Afterwards rr = 0 (wrapped).
- cmd_ch = 12, or cmd_steps = 0 -> cmd_reject; no state change.
- Load ch 1 with mc_active[1] held low -> fault[1] at L+16. Abort ch 1 -> fault and queue cleared.
- Abort ch 4 and cmd_valid ch 4 in the same cycle, with one entry queued -> reject, no mc_load, count 0.
